// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer_if
// Purpose  : Request/result bundle between the control unit and the
//            multi-cycle signed multiply/divide sequencer.
// Signals  : start    - request pulse (sampled only while sequencer is idle)
//            op       - 0 = signed MULT, 1 = signed DIV
//            a, b     - operands rs / rt (32 bits each)
//            busy     - operation in progress
//            done     - one-cycle completion pulse, hi/lo valid from here
//            div_zero - one-cycle pulse, DIV with b == 0
//            hi, lo   - HI/LO result registers
// Modports : master (control unit side), slave (sequencer side)
// Revision : 1.0  initial release
// ============================================================================
interface muldiv_sequencer_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Multi-cycle signed 32x32 multiply (shift-add) and signed
//            32/32 divide (restoring) producing HI/LO results.
//            Timing from the capture edge N: iterations on N+1..N+32,
//            sign fix-up and HI/LO load on N+33, done high the cycle after.
//            DIV by zero skips straight to DONE with div_zero, HI/LO kept.
// Ports    : clk   - system clock, rising edge
//            reset - synchronous active-high reset
//            bus   - muldiv_sequencer_if.slave (start/op/a/b in,
//                    busy/done/div_zero/hi/lo out)
// Revision : 1.0  initial release
// ============================================================================
module muldiv_sequencer (
    input  wire logic               clk,
    input  wire logic               reset,
    muldiv_sequencer_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0] C_LAST_ITER = 6'd31;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_op;        // 0 = MULT, 1 = DIV
    logic        r_neg_res;   // product / quotient must be negated
    logic        r_neg_rem;   // remainder must be negated (dividend < 0)
    logic        r_dz;        // current DONE visit is a divide-by-zero
    logic [31:0] r_operand;   // |a| for MULT (multiplicand), |b| for DIV (divisor)
    logic [63:0] r_acc;       // MULT: product accumulator; DIV: [31:0] dividend->quotient
    logic [31:0] r_rem;       // DIV partial remainder (always < divisor)
    logic [5:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // ------------------------------------------------------------------
    // Operand magnitudes. 0x80000000 maps to itself, which is the correct
    // unsigned magnitude 2^31.
    // ------------------------------------------------------------------
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    assign w_mag_a = bus.a[31] ? (32'd0 - bus.a) : bus.a;
    assign w_mag_b = bus.b[31] ? (32'd0 - bus.b) : bus.b;

    // ------------------------------------------------------------------
    // Shift-add multiply step: multiplier sits in acc[31:0] and is
    // consumed LSB first; the 33-bit sum keeps the carry that is shifted
    // back into the top of the accumulator.
    // ------------------------------------------------------------------
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_operand} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // ------------------------------------------------------------------
    // Restoring divide step on a 33-bit working remainder. Because the
    // stored remainder is below the divisor, the shifted value is below
    // 2*divisor, so bit 32 of the trial difference is a clean borrow flag.
    // ------------------------------------------------------------------
    logic [32:0] w_rem_shift;
    logic [32:0] w_trial;
    logic        w_fits;
    logic [31:0] w_div_rem;
    logic [31:0] w_div_quot;
    assign w_rem_shift = {r_rem, r_acc[31]};
    assign w_trial     = w_rem_shift - {1'b0, r_operand};
    assign w_fits      = ~w_trial[32];
    assign w_div_rem   = w_fits ? w_trial[31:0] : w_rem_shift[31:0];
    assign w_div_quot  = {r_acc[30:0], w_fits};

    // ------------------------------------------------------------------
    // Sign correction applied on the FIX edge.
    // ------------------------------------------------------------------
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_hi_fix;
    logic [31:0] w_lo_fix;
    assign w_prod_fix = r_neg_res ? (64'd0 - r_acc) : r_acc;
    assign w_quot_fix = r_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem_fix  = r_neg_rem ? (32'd0 - r_rem) : r_rem;
    assign w_hi_fix   = r_op ? w_rem_fix  : w_prod_fix[63:32];
    assign w_lo_fix   = r_op ? w_quot_fix : w_prod_fix[31:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.op && (bus.b == 32'd0)) ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_count == C_LAST_ITER) begin
                    w_state_next = FIX;
                end
            end
            FIX:     w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_operand <= 32'd0;
            r_acc     <= 64'd0;
            r_rem     <= 32'd0;
            r_count   <= 6'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op      <= bus.op;
                        r_dz      <= bus.op && (bus.b == 32'd0);
                        r_neg_res <= bus.a[31] ^ bus.b[31];
                        r_neg_rem <= bus.a[31];
                        r_count   <= 6'd0;
                        r_rem     <= 32'd0;
                        if (bus.op) begin
                            r_operand <= w_mag_b;
                            r_acc     <= {32'd0, w_mag_a};
                        end else begin
                            r_operand <= w_mag_a;
                            r_acc     <= {32'd0, w_mag_b};
                        end
                    end
                end
                CALC: begin
                    r_count <= r_count + 6'd1;
                    if (r_op) begin
                        r_rem <= w_div_rem;
                        r_acc <= {32'd0, w_div_quot};
                    end else begin
                        r_acc <= w_mul_next;
                    end
                end
                FIX: begin
                    r_hi <= w_hi_fix;
                    r_lo <= w_lo_fix;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == DONE);
    assign bus.div_zero = (r_state == DONE) && r_dz;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Self-checking bench for muldiv_sequencer. A cycle-count model
//            computes results with plain 64-bit signed arithmetic and the
//            expected busy/done/div_zero timeline; outputs are compared on
//            every falling edge. Directed cases pin literal values.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // ------------------------------------------------------------------
    // Reference model: cycles left until idle, pending and visible HI/LO
    // ------------------------------------------------------------------
    int          m_left = 0;
    bit          m_dz   = 1'b0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [31:0] p_hi   = 32'd0;
    logic [31:0] p_lo   = 32'd0;

    function automatic void ref_calc(input logic opx, input logic [31:0] ax,
                                     input logic [31:0] bx,
                                     output logic [31:0] rh, output logic [31:0] rl);
        longint      sa;
        longint      sb;
        longint      r;
        logic [63:0] v;
        sa = longint'($signed(ax));
        sb = longint'($signed(bx));
        if (!opx) begin
            r  = sa * sb;
            v  = r;
            rh = v[63:32];
            rl = v[31:0];
        end else begin
            r  = sa / sb;
            v  = r;
            rl = v[31:0];
            r  = sa % sb;
            v  = r;
            rh = v[31:0];
        end
    endfunction

    logic [31:0] t_hi;
    logic [31:0] t_lo;
    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_dz   <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else if (m_left == 0) begin
            if (bus.start) begin
                if (bus.op && bus.b == 32'd0) begin
                    m_left <= 1;
                    m_dz   <= 1'b1;
                end else begin
                    ref_calc(bus.op, bus.a, bus.b, t_hi, t_lo);
                    p_hi   <= t_hi;
                    p_lo   <= t_lo;
                    m_left <= 34;   // 32 CALC + FIX + DONE
                    m_dz   <= 1'b0;
                end
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [66:0] act;
            logic [66:0] exp;
            act = {bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo};
            exp = {(m_left != 0), (m_left == 1), (m_left == 1) && m_dz, m_hi, m_lo};
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL cycle_compare t=%0t busy/done/dz/hi/lo got %b/%b/%b/%h/%h want %b/%b/%b/%h/%h",
                         $time, act[66], act[65], act[64], act[63:32], act[31:0],
                         exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for done; n = cycles waited, -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 0; i < 60; i++) begin
            if (bus.done) begin
                n = i;
                break;
            end
            step();
        end
    endtask

    // Issues one request, checks latency/result, and pokes start during the
    // done cycle, which must be ignored.
    task automatic run_op(input string name, input logic opx, input logic [31:0] ax,
                          input logic [31:0] bx, input int exp_lat, input logic exp_dz,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        bus.start = 1'b1;
        bus.op    = opx;
        bus.a     = ax;
        bus.b     = bx;
        step();
        bus.start = 1'b0;
        wait_done(n);
        lit({name, "_latency"}, 64'(n), 64'(exp_lat));
        lit({name, "_div_zero"}, {63'd0, bus.div_zero}, {63'd0, exp_dz});
        lit({name, "_hilo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 32'd7;
        bus.b     = 32'd9;
        step();
        bus.start = 1'b0;
        lit({name, "_idle_after"}, {63'd0, bus.busy}, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom();
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        step();
        chk_en = 1'b1;
        step();
        lit("reset_state", {29'd0, bus.busy, bus.done, bus.div_zero, bus.hi},
            {32'd0, 32'd0});
        lit("reset_lo", {32'd0, bus.lo}, 64'd0);
        reset = 1'b0;

        // Directed cases with hand-computed results
        run_op("mult_m1_x2", 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 33, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_by_zero", 1'b1, 32'h0000_0005, 32'h0000_0000, 0, 1'b1,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0,
               32'h0000_0000, 32'h8000_0000);
        run_op("div_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 33, 1'b0,
               32'h0000_0001, 32'hFFFF_FFFD);
        run_op("mult_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 33, 1'b0,
               32'h4000_0000, 32'h0000_0000);

        // Second start while busy is ignored
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 32'h0001_2345;
        bus.b     = 32'h0001_0000;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 32'h0000_0064;
        bus.b     = 32'h0000_0003;
        step();
        bus.start = 1'b0;
        wait_done(n);
        lit("busy_restart_latency", 64'(n + 10), 64'd33);
        lit("busy_restart_hilo", {bus.hi, bus.lo}, {32'h0000_0001, 32'h2345_0000});
        step();

        // Reset in the middle of CALC, with a simultaneous start
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h9ABC_DEF0;
        step();
        bus.start = 1'b0;
        repeat (15) step();
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        lit("mid_calc_reset", {31'd0, bus.busy, bus.hi}, 64'd0);
        lit("mid_calc_reset_lo", {32'd0, bus.lo}, 64'd0);
        run_op("mult_3x4", 1'b0, 32'd3, 32'd4, 33, 1'b0, 32'd0, 32'h0000_000C);

        // Random traffic: frequent start pulses (many while busy), edge-case
        // operands, occasional resets
        for (int c = 0; c < 4000; c++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 1'($urandom_range(0, 1));
            bus.a     = pick();
            bus.b     = pick();
            reset     = ($urandom_range(0, 699) == 0);
            step();
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (40) step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on clk rising edge.
REQ-003 start  input  1  request pulse from control unit; sampled only in IDLE.
REQ-004 op  input  1  0 = signed MULT, 1 = signed DIV; captured with start.
REQ-005 a  input  32  operand rs (multiplicand / dividend); captured with start.
REQ-006 b  input  32  operand rt (multiplier / divisor); captured with start.
REQ-007 busy  output  1  high while an operation is in progress (any state except IDLE).
REQ-008 done  output  1  one-cycle pulse; hi/lo valid and stable from this cycle.
REQ-009 div_zero  output  1  one-cycle pulse; DIV requested with b == 0.
REQ-010 hi  output  32  HI result register: product[63:32] or remainder.
REQ-011 lo  output  32  LO result register: product[31:0] or quotient.

Function
REQ-012 The FSM SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-013 IDLE with start=1 SHALL do the following on the capture edge N: latch op, take magnitudes of a and b, record the result signs, clear the 6-bit iteration counter, and enter CALC.
REQ-014 IDLE with start=1, op=1 and b==0 SHALL instead enter DONE with div_zero flagged, leaving hi/lo unchanged.
REQ-015 CALC SHALL perform exactly one iteration per cycle for 32 cycles (edges N+1..N+32), then enter FIX.
REQ-016 MULT iteration SHALL be unsigned shift-add on the magnitudes, using a 64-bit product accumulator.
REQ-017 DIV iteration SHALL be unsigned restoring divide on the magnitudes, using a 33-bit partial remainder.
REQ-018 FIX (edge N+33) SHALL apply sign correction, load hi/lo, and enter DONE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
REQ-019 DONE SHALL assert done=1 for exactly one cycle and return to IDLE on the next edge.
  - Normal completion: done is high in the cycle following edge N+33.
  - Divide-by-zero path: done=1 and div_zero=1 in the cycle following edge N.
REQ-020 busy SHALL be 1 in CALC, FIX and DONE, and 0 in IDLE.
REQ-021 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-022 start may be asserted in the same cycle done=1; it SHALL be ignored, since the FSM is in DONE, not IDLE.
REQ-023 hi/lo SHALL change only on the FIX edge or on reset, and SHALL hold between operations.
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no exception.
REQ-025 Quotients SHALL truncate toward zero, and the remainder SHALL carry the sign of the dividend.

Reset
REQ-026 reset=1 SHALL force the following on the next edge, regardless of state (including mid-CALC):
  - state = IDLE;
  - hi = lo = 0, counter = 0;
  - busy = done = div_zero = 0.
REQ-027 reset SHALL take priority over start in the same cycle.
REQ-028 After reset is released, the first start SHALL be accepted on the next edge.

Verification
REQ-029 MULT a=0xFFFFFFFF, b=0x00000002 -> done pulses 33 cycles after the capture edge; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-030 DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
REQ-031 DIV a=0x00000005, b=0 -> one cycle later done=1 and div_zero=1; hi/lo keep their prior values; busy high exactly one cycle.
REQ-032 MULT 0x00012345 x 0x00010000 started; start re-pulsed with different operands at cycle 10 -> second request ignored; hi=0x00000001, lo=0x23450000.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-034 reset asserted at CALC iteration 15 -> next cycle busy=0, hi=lo=0; a new MULT 3x4 then completes with lo=0x0000000C, hi=0.
